// File: rtl/rep5_tx.sv
// rep5_tx: 5x repetition-code serial transmitter.
// Accepts a DATA_W-bit word over valid/ready and shifts it out LSB-first,
// holding each bit on tx_out for 5 consecutive cycles.
// Optional feature macro: REP5_TX_PARITY_EN appends one even-parity bit,
// also repeated 5 times, after the data bits.
module rep5_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_valid,
  output logic              tx_first,
  output logic              tx_last
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

`ifdef REP5_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  // One serial symbol together with its framing flags.
  typedef struct packed {
    logic out;
    logic valid;
    logic first;
    logic last;
  } tx_sym_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        rep_q,   rep_d;
  logic [BW-1:0]     bit_q,   bit_d;
  tx_sym_t           sym_q,   sym_d;
`ifdef REP5_TX_PARITY_EN
  logic              par_q,   par_d;
`endif

  // Next-state: accept in IDLE, count repetitions and bits while sending.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
`ifdef REP5_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEND;
          shreg_d = in_data;
          rep_d   = 3'd0;
          bit_d   = '0;
`ifdef REP5_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SEND: begin
        if (rep_q == 3'd4) begin
          rep_d   = 3'd0;
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef REP5_TX_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          rep_d = rep_q + 3'd1;
        end
      end
`ifdef REP5_TX_PARITY_EN
      PAR: begin
        if (rep_q == 3'd4) begin
          rep_d   = 3'd0;
          state_d = IDLE;
        end else begin
          rep_d = rep_q + 3'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next-state values so tx_* come straight from flops.
  always_comb begin
    sym_d = '0;
    case (state_d)
      SEND: begin
        sym_d.out   = shreg_d[0];
        sym_d.valid = 1'b1;
        sym_d.first = (bit_d == '0) && (rep_d == 3'd0);
`ifndef REP5_TX_PARITY_EN
        sym_d.last  = (bit_d == LAST_BIT) && (rep_d == 3'd4);
`endif
      end
`ifdef REP5_TX_PARITY_EN
      PAR: begin
        sym_d.out   = par_d;
        sym_d.valid = 1'b1;
        sym_d.last  = (rep_d == 3'd4);
      end
`endif
      default: sym_d = '0;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rep_q   <= 3'd0;
      bit_q   <= '0;
      sym_q   <= '0;
`ifdef REP5_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      sym_q   <= sym_d;
`ifdef REP5_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign tx_out   = sym_q.out;
  assign tx_valid = sym_q.valid;
  assign tx_first = sym_q.first;
  assign tx_last  = sym_q.last;

endmodule

// File: tb/tb_rep5_tx.sv
// tb_rep5_tx: directed frames with literal expectations plus a randomized
// run, all checked every cycle against a symbol-queue model of the link.
module tb_rep5_tx;
  localparam int W  = 8;
`ifdef REP5_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F  = 5 * (W + PB);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, tx_out, tx_valid, tx_first, tx_last;

  rep5_tx #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_out(tx_out), .tx_valid(tx_valid),
    .tx_first(tx_first), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is just a list of symbols; the line shows one per cycle.
  typedef struct packed {
    logic out;
    logic valid;
    logic first;
    logic last;
  } sym_t;

  sym_t mq[$];
  sym_t cur = '0;
  logic armed = 1'b0;

  function automatic void build_frame(input logic [W-1:0] d);
    sym_t s;
    for (int b = 0; b < W; b++)
      for (int r = 0; r < 5; r++) begin
        s.out = d[b]; s.valid = 1'b1;
        s.first = (b == 0 && r == 0);
        s.last  = (PB == 0 && b == W-1 && r == 4);
        mq.push_back(s);
      end
    if (PB == 1)
      for (int r = 0; r < 5; r++) begin
        s.out = ^d; s.valid = 1'b1; s.first = 1'b0; s.last = (r == 4);
        mq.push_back(s);
      end
  endfunction

  // Model advance: reset clears, idle line accepts, else next symbol.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      cur = '0;
    end else if (in_valid && !cur.valid) begin
      build_frame(in_data);
      cur = mq.pop_front();
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
    end else begin
      cur = '0;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, !cur.valid);
      chk("tx_out",   tx_out,   cur.out);
      chk("tx_valid", tx_valid, cur.valid);
      chk("tx_first", tx_first, cur.first);
      chk("tx_last",  tx_last,  cur.last);
    end
  end

  logic [F-1:0] cap_out, cap_first, cap_last, cap_valid;

  // Wait (bounded) for in_ready, then present one word for one accept.
  task automatic start_frame(input logic [W-1:0] d);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", (n < 200), 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Record F symbols starting in cycle 1; optionally pulse in_valid once.
  task automatic capture(input int pulse_at, input logic [W-1:0] pd);
    for (int k = 1; k <= F; k++) begin
      cap_out[k-1]   = tx_out;
      cap_first[k-1] = tx_first;
      cap_last[k-1]  = tx_last;
      cap_valid[k-1] = tx_valid;
      if (k == pulse_at) begin in_valid = 1'b1; in_data = pd; end
      else if (k == pulse_at + 1) in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic [44:0] exp_out);
    logic [F-1:0] one_hot_first, one_hot_last, ones;
    one_hot_first = '0; one_hot_first[0]   = 1'b1;
    one_hot_last  = '0; one_hot_last[F-1]  = 1'b1;
    ones = '1;
    chk({name, "_out"},   cap_out,   exp_out[F-1:0]);
    chk({name, "_first"}, cap_first, one_hot_first);
    chk({name, "_last"},  cap_last,  one_hot_last);
    chk({name, "_valid"}, cap_valid, ones);
    chk({name, "_ready_after"}, in_ready, 1'b1);
    chk({name, "_gap"},         tx_valid, 1'b0);
  endtask

  localparam logic [44:0] EXP_A5 = 45'b00000_11111_00000_11111_00000_00000_11111_00000_11111;
  localparam logic [44:0] EXP_0F = {25'b0, 20'hFFFFF};
  localparam logic [44:0] EXP_01 = {5'b11111, 35'b0, 5'b11111};
  localparam logic [44:0] EXP_03 = {35'b0, 10'h3FF};

  initial begin
    int gaps, bad1, bad2;
    logic [2*F:0] bv, bo;

    // Reset values.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_out",   tx_out,   1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_first", tx_first, 1'b0);
    chk("rst_last",  tx_last,  1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame.
    start_frame(8'hA5);
    capture(0, '0);
    check_frame("a5", EXP_A5);

    // Busy ignore: a pulse of 8'h3C in cycle 10 must not disturb or queue.
    repeat (2) @(negedge clk);
    start_frame(8'hA5);
    capture(10, 8'h3C);
    check_frame("busy", EXP_A5);
    gaps = 0;
    for (int k = 0; k < 8; k++) begin
      if (tx_valid) gaps++;
      @(negedge clk);
    end
    chk("busy_no_extra", gaps, 0);

    // Back-to-back with in_valid held: FF then 00.
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    in_data  = 8'h00;
    for (int k = 1; k <= 2*F+1; k++) begin
      bv[k-1] = tx_valid;
      bo[k-1] = tx_out;
      if (k == F + 2) in_valid = 1'b0;
      @(negedge clk);
    end
    gaps = 0; bad1 = 0; bad2 = 0;
    for (int k = 1; k <= 2*F+1; k++) begin
      if (!bv[k-1]) gaps++;
      if (k <= F && bo[k-1] !== (k <= 5*W)) bad1++;
      if (k > F + 1 && bo[k-1] !== 1'b0) bad2++;
    end
    chk("b2b_gap_count", gaps, 1);
    chk("b2b_gap_pos",   bv[F], 1'b0);
    chk("b2b_frame1",    bad1, 0);
    chk("b2b_frame2",    bad2, 0);

    // Mid-frame reset in cycle 17, then a clean 8'h0F frame.
    repeat (2) @(negedge clk);
    start_frame(8'h5A);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_out",   tx_out,   1'b0);
    chk("mrst_valid", tx_valid, 1'b0);
    chk("mrst_first", tx_first, 1'b0);
    chk("mrst_last",  tx_last,  1'b0);
    reset = 1'b0;
    @(negedge clk);
    start_frame(8'h0F);
    capture(0, '0);
    check_frame("f0f", EXP_0F);

`ifdef REP5_TX_PARITY_EN
    start_frame(8'h01);
    capture(0, '0);
    check_frame("par01", EXP_01);
    start_frame(8'h03);
    capture(0, '0);
    check_frame("par03", EXP_03);
`else
    chk("lit_pin_01", EXP_01[39:0], {35'b0, 5'b11111});
    chk("lit_pin_03", EXP_03[39:0], {30'b0, 10'h3FF});
`endif

    // Randomized traffic with occasional resets; the compare process checks.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      reset    = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (F + 5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rep5_tx.md
# rep5_tx

- Serial transmitter for a 5× repetition code: accepts a parallel data word over a valid/ready handshake and shifts it out LSB-first, each bit held for exactly 5 consecutive clock cycles.
- Forms the transmit end of the link whose receive end recovers each bit with the 5-bit majority voter, so up to 2 corrupted symbols per bit are tolerated.
- Sits between the parallel data source and the serial line.

## Interface
- DATA_W, 8, data word width in bits (≥1).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a word on in_data.
- in_data  input  DATA_W  word to transmit; sampled only on accept.
- in_ready  output  1  block can accept a word (high only in IDLE).
- tx_out  output  1  serial symbol.
- tx_valid  output  1  tx_out carries a frame symbol this cycle.
- tx_first  output  1  first symbol of a frame.
- tx_last  output  1  final symbol of a frame.
- Clock/reset: one clock `clk`; reset `reset` is synchronous and active-high.

## Operation
- States:
  - IDLE: in_ready=1; tx_out/tx_valid/tx_first/tx_last = 0.
  - SEND: data bits.
  - PAR: parity bit, only when the configuration macro is defined.
- Accept: `in_valid & in_ready` at a rising edge in IDLE.
  - Latch in_data into the shift register; clear rep_cnt (0..4) and bit_cnt (0..DATA_W-1).
  - Go to SEND.
- SEND:
  - tx_out = shreg[0]; tx_valid=1.
  - rep_cnt increments every cycle.
  - When rep_cnt==4: rep_cnt→0, shreg shifts right by 1, bit_cnt increments.
  - After bit DATA_W-1 completes its 5th symbol: go to PAR if enabled, else IDLE.
- PAR: tx_out = even parity (XOR of the latched word) for 5 cycles, then go to IDLE.
- tx_first: high on the first SEND cycle (bit 0, rep 0) only.
- tx_last: high on the final symbol of the frame only.
  - Last data symbol without parity; 5th parity symbol with parity.
- Busy behaviour: in_valid while not IDLE is ignored (no accept, no loss of the current frame); the source must hold its word.
- in_data changes after accept have no effect on the frame in flight.
- Reset:
  - Reset asserted at any time, including mid-frame, aborts the frame.
  - At that edge: state→IDLE, counters→0, shreg→0, tx_* outputs→0, in_ready→1.
  - No partial bit is completed.
- Reset has priority over accept in the same cycle.

## Timing
- All tx_* outputs are registered; in_ready decodes from the state register.
- Accept at edge t → first symbol (tx_first=1) is visible in cycle t+1.
- Frame length F = 5·DATA_W cycles, or 5·(DATA_W+1) with parity (40/45 for DATA_W=8).
- tx_last in cycle t+F; IDLE (in_ready=1) in cycle t+F+1.
- Minimum frame-to-frame spacing is F+1 cycles, with exactly one idle gap cycle of tx_valid=0 between back-to-back frames.
- tx_valid is continuous (no bubbles) within a frame.

## Configuration
- REP5_TX_PARITY_EN defined:
  - PAR state compiled in; one even-parity bit appended after the data bits, repeated 5 times.
  - F = 5·(DATA_W+1).
- Undefined:
  - No PAR state or parity logic.
  - Frame ends after the last data bit; F = 5·DATA_W.

## Test plan
- Reset values: assert reset 2 cycles → in_ready=1, tx_out=0, tx_valid=0, tx_first=0, tx_last=0.
- Basic frame: send 8'hA5 with macro undefined.
  - tx_out over cycles 1–40 = 11111 00000 11111 00000 00000 11111 00000 11111.
  - tx_first in cycle 1, tx_last in cycle 40, in_ready=1 in cycle 41.
- Back-to-back: in_valid held high with 8'hFF then 8'h00.
  - Second accept occurs in cycle 41; exactly one tx_valid=0 gap cycle.
  - Second frame is 40 zero symbols.
- Busy ignore: pulse in_valid with 8'h3C at cycle 10 of an 8'hA5 frame → 8'hA5 frame unchanged; 8'h3C is never transmitted.
- Mid-frame reset: assert reset at cycle 17 of a frame → next cycle all outputs at reset values; a new 8'h0F accept afterwards produces a full, clean 40-cycle frame.
- Parity (REP5_TX_PARITY_EN defined):
  - 8'h01 → 45-cycle frame; cycles 41–45 tx_out=1, tx_last in cycle 45.
  - 8'h03 → cycles 41–45 tx_out=0.
